// File: rtl/spi_pkg.sv
// Shared SPI frame constants and controller state encoding.
// Also used by the peripheral-side FSM, so keep the RW encoding stable.
package spi_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = ADDR_W + 1 + DATA_W;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick: one-cycle pulse every CLK_DIV clk cycles while enabled.
// Counter is held at zero whenever enable is low, so the first tick comes CLK_DIV cycles after enable.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 controller: one 16-bit frame (addr, rw, data) per accepted start; accept-to-done is 1 + 33*CLK_DIV cycles.
// start is only looked at while idle; requests during a frame or its CS-high gap are dropped, not queued.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  import spi_pkg::*;

  localparam int FL = ADDR_W + 1 + DATA_W;
  localparam int CW = $clog2(FL + 1);

  state_t            state;
  logic [FL-1:0]     tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              rw_q;
  logic [CW-1:0]     bit_cnt;
  logic              tick;
  logic              div_en;

  assign div_en = (state != ST_IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .enable (div_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rw_q    <= 1'b0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr   <= {addr, rw, (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}}};
            rw_q    <= rw;
            rx_sr   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            mosi    <= addr[ADDR_W-1];
            state   <= ST_LEAD;
          end
        end
        ST_LEAD, ST_LOW: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= ST_HIGH;
            // miso is stable here: the peripheral moved it on the previous sclk fall
            if (rw_q == RW_READ && bit_cnt >= CW'(ADDR_W + 1)) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(FL - 1)) begin
              state <= ST_TRAIL;
            end else begin
              tx_sr <= {tx_sr[FL-2:0], 1'b0};
              mosi  <= tx_sr[FL-2];
              state <= ST_LOW;
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            done  <= 1'b1;
            if (rw_q == RW_READ) begin
              rdata <= rx_sr;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: instance a (CLK_DIV=2) for single frames, instance b (CLK_DIV=1) for back-to-back frames.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, rw_a = 1'b0;
  logic [6:0] addr_a = '0;
  logic [7:0] wdata_a = '0;
  logic       busy_a, done_a, sclk_a, cs_n_a, mosi_a;
  logic [7:0] rdata_a;
  logic       miso_a = 1'bx;

  logic       start_b = 1'b0, rw_b = 1'b0;
  logic [6:0] addr_b = 7'h55;
  logic [7:0] wdata_b = 8'hAA;
  logic       busy_b, done_b, sclk_b, cs_n_b, mosi_b;
  logic [7:0] rdata_b;
  logic       miso_b = 1'b0;

  spi_master #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rw(rw_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .sclk(sclk_a), .cs_n(cs_n_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .sclk(sclk_b), .cs_n(cs_n_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  int total = 0;
  int bad = 0;

  // monitor + peripheral model for instance a
  int          cyc = 0, rises_a = 0, falls_a = 0, cslow_a = 0, dones_a = 0;
  int          acc_cyc_a = 0, done_cyc_a = 0;
  logic [15:0] bits_a = '0;
  logic [7:0]  rdata_done_a = '0, rdata_pre_a = '0, rdata_last_a = '0;
  logic        sclk_q_a = 1'b0;
  logic        rd_mode_a = 1'b0;
  logic [7:0]  rd_byte_a = '0;

  always @(negedge clk) begin
    cyc++;
    if (start_a && !busy_a && !reset) acc_cyc_a = cyc;
    if (sclk_a && !sclk_q_a) begin
      rises_a++;
      bits_a = {bits_a[14:0], mosi_a};
    end
    if (cs_n_a) falls_a = 0;
    else if (!sclk_a && sclk_q_a) falls_a++;
    if (rd_mode_a && !cs_n_a && falls_a >= 8 && falls_a <= 15) miso_a = rd_byte_a[15 - falls_a];
    else miso_a = 1'bx;
    if (!cs_n_a) cslow_a++;
    if (done_a) begin
      dones_a++;
      done_cyc_a = cyc;
      rdata_done_a = rdata_a;
      rdata_pre_a = rdata_last_a;
    end
    rdata_last_a = rdata_a;
    sclk_q_a = sclk_a;
  end

  // monitor for instance b
  int   rises_b = 0, dones_b = 0, cslow_b = 0, cs_hi_run_b = 0, min_gap_b = 1000;
  int   rise_at_done_b [0:7];
  logic sclk_q_b = 1'b0, had_low_b = 1'b0;

  always @(negedge clk) begin
    if (sclk_b && !sclk_q_b) rises_b++;
    if (cs_n_b) cs_hi_run_b++;
    else begin
      if (had_low_b && cs_hi_run_b != 0 && cs_hi_run_b < min_gap_b) min_gap_b = cs_hi_run_b;
      cs_hi_run_b = 0;
      had_low_b = 1'b1;
      cslow_b++;
    end
    if (done_b) begin
      if (dones_b < 8) rise_at_done_b[dones_b] = rises_b;
      dones_b++;
    end
    sclk_q_b = sclk_b;
  end

  task automatic frame_a(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
    @(posedge clk); #1;
    rw_a = rw; addr_a = addr; wdata_a = wdata; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int d0);
    for (int i = 0; i < 400 && dones_a == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (cs_n_a !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", cs_n_a); end
    total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", sclk_a); end
    total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_a); end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", rdata_a); end
    total++; if (cs_n_b !== 1'b1) begin bad++; $display("FAIL rst_cs_n_b: got %b want 1", cs_n_b); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++; if ({cs_n_a, sclk_a, mosi_a, busy_a} !== 4'b1000) begin
      bad++; $display("FAIL rst_async_idle: got %b want 1000", {cs_n_a, sclk_a, mosi_a, busy_a});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_write();
    int r0, c0, d0;
    r0 = rises_a; c0 = cslow_a; d0 = dones_a;
    rd_mode_a = 1'b0;
    frame_a(1'b0, 7'h2A, 8'hC5);
    wait_done_a(d0);
    total++; if (rises_a - r0 !== 16) begin bad++; $display("FAIL wr_rises: got %0d want 16", rises_a - r0); end
    total++; if (bits_a !== 16'h54C5) begin bad++; $display("FAIL wr_mosi: got %h want 54c5", bits_a); end
    total++; if (cslow_a - c0 !== 66) begin bad++; $display("FAIL wr_cs_low: got %0d want 66", cslow_a - c0); end
    total++; if (dones_a - d0 !== 1) begin bad++; $display("FAIL wr_done_cnt: got %0d want 1", dones_a - d0); end
    total++; if (done_cyc_a - acc_cyc_a !== 67) begin
      bad++; $display("FAIL wr_latency: got %0d want 67", done_cyc_a - acc_cyc_a);
    end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL wr_rdata: got %h want 00", rdata_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", busy_a); end
  endtask

  task automatic test_read();
    int r0, d0;
    r0 = rises_a; d0 = dones_a;
    rd_mode_a = 1'b1; rd_byte_a = 8'h96;
    frame_a(1'b1, 7'h7F, 8'h5A);
    wait_done_a(d0);
    rd_mode_a = 1'b0;
    total++; if (rises_a - r0 !== 16) begin bad++; $display("FAIL rd_rises: got %0d want 16", rises_a - r0); end
    total++; if (bits_a !== 16'hFF00) begin bad++; $display("FAIL rd_mosi: got %h want ff00", bits_a); end
    total++; if (rdata_done_a !== 8'h96) begin bad++; $display("FAIL rd_rdata_done: got %h want 96", rdata_done_a); end
    total++; if (rdata_pre_a !== 8'h00) begin bad++; $display("FAIL rd_rdata_early: got %h want 00", rdata_pre_a); end
    total++; if (rdata_a !== 8'h96) begin bad++; $display("FAIL rd_rdata_hold: got %h want 96", rdata_a); end
  endtask

  task automatic test_ignore_busy();
    int r0, d0;
    r0 = rises_a; d0 = dones_a;
    frame_a(1'b0, 7'h15, 8'h3C);
    repeat (10) @(posedge clk);
    #1 addr_a = 7'h00; wdata_a = 8'hFF; rw_a = 1'b1; start_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_a = 1'b0;
    wait_done_a(d0);
    repeat (120) @(negedge clk);
    total++; if (dones_a - d0 !== 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", dones_a - d0); end
    total++; if (rises_a - r0 !== 16) begin bad++; $display("FAIL ign_rises: got %0d want 16", rises_a - r0); end
    total++; if (bits_a !== 16'h2A3C) begin bad++; $display("FAIL ign_mosi: got %h want 2a3c", bits_a); end
    total++; if (rdata_a !== 8'h96) begin bad++; $display("FAIL ign_rdata: got %h want 96", rdata_a); end
  endtask

  task automatic test_reset_midframe();
    int r0, c0, d0;
    r0 = rises_a; d0 = dones_a;
    frame_a(1'b0, 7'h33, 8'hFF);
    for (int i = 0; i < 200 && rises_a - r0 < 5; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (rises_a - r0 !== 5) begin bad++; $display("FAIL mid_rise_reach: got %0d want 5", rises_a - r0); end
    total++; if ({cs_n_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
      bad++; $display("FAIL mid_rst_pins: got %b want 10000", {cs_n_a, sclk_a, mosi_a, busy_a, done_a});
    end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL mid_rst_rdata: got %h want 00", rdata_a); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    r0 = rises_a; c0 = cslow_a; d0 = dones_a;
    frame_a(1'b0, 7'h11, 8'hA0);
    wait_done_a(d0);
    total++; if (rises_a - r0 !== 16) begin bad++; $display("FAIL post_rises: got %0d want 16", rises_a - r0); end
    total++; if (bits_a !== 16'h22A0) begin bad++; $display("FAIL post_mosi: got %h want 22a0", bits_a); end
    total++; if (cslow_a - c0 !== 66) begin bad++; $display("FAIL post_cs_low: got %0d want 66", cslow_a - c0); end
    total++; if (dones_a - d0 !== 1) begin bad++; $display("FAIL post_done_cnt: got %0d want 1", dones_a - d0); end
  endtask

  task automatic test_back_to_back();
    int r0, c0;
    r0 = rises_b; c0 = cslow_b;
    @(posedge clk); #1 start_b = 1'b1;
    for (int i = 0; i < 600 && dones_b < 3; i++) @(negedge clk);
    #1 start_b = 1'b0;
    total++; if (dones_b !== 3) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 3", dones_b); end
    for (int k = 0; k < 3; k++) begin
      total++; if (rise_at_done_b[k] - r0 !== 16 * (k + 1)) begin
        bad++; $display("FAIL b2b_rises_f%0d: got %0d want %0d", k, rise_at_done_b[k] - r0, 16 * (k + 1));
      end
    end
    total++; if (cslow_b - c0 !== 99) begin bad++; $display("FAIL b2b_cs_low: got %0d want 99", cslow_b - c0); end
    total++; if (min_gap_b < 1 || min_gap_b > 100) begin
      bad++; $display("FAIL b2b_cs_gap: got %0d want 1..100", min_gap_b);
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_busy();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI controller (initiator) for the team's SPI peripheral/memory block; sits between a local host interface and the four SPI pins.
- On a `start` request it runs one 16-bit frame: 7-bit address plus R/W bit, then 8 data bits. It drives `cs_n`, `sclk` and `mosi`, and samples `miso`.
- Reads return the captured byte on `rdata`. Writes shift `wdata` out on `mosi`.
- SPI mode 0: `sclk` idles low. Peripheral samples on `sclk` rise and changes `miso` on `sclk` fall.

Parameters:
- CLK_DIV, 4, `clk` cycles per `sclk` half-period; legal range ≥1.
- ADDR_W, 7, address bits per frame; fixed at 7 for this protocol.
- DATA_W, 8, data bits per frame.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, transaction request; sampled only when `busy`=0.
- rw, input, 1, 1=read, 0=write; latched at accept.
- addr, input, 7, target address; latched at accept.
- wdata, input, 8, write byte; latched at accept.
- busy, output, 1, high from accept through end of CS-high gap.
- done, output, 1, one-cycle pulse at end of frame.
- rdata, output, 8, last read byte.
- sclk, output, 1, SPI clock.
- cs_n, output, 1, chip select, active low.
- mosi, output, 1, controller-to-peripheral data.
- miso, input, 1, peripheral-to-controller data.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=0, state=IDLE, counters=0.
- Outputs: all registered, no combinational paths from inputs.
- Frame format, MSB first on `mosi`: addr[6], …, addr[0], rw, then 8 data bits.
  - Write: data bits are wdata[7:0].
  - Read: `mosi`=0 during the data phase.
- Half-period tick: a divider counts CLK_DIV `clk` cycles. All phase changes happen on the tick; the divider is held at 0 in IDLE.
- State machine (one-hot or binary; encoding lives in the package):
  - IDLE: `busy`=0, `cs_n`=1. On `start`=1, latch rw/addr/wdata into a 16-bit shift register. Next cycle: `busy`=1, `cs_n`=0, `mosi`=frame bit 15, go to LEAD.
  - LEAD: `sclk` low for CLK_DIV cycles, then `sclk`→1, go to HIGH.
  - HIGH: on entry, i.e. the `sclk` rising edge, sample `miso` into the read shift register.
    - Read frames: only data-phase samples (bits 7..0) are kept.
    - `sclk` stays high for CLK_DIV cycles, then `sclk`→0. Bit count increments.
    - Count <16: shift, `mosi`=next bit, go to LOW.
    - Count ==16: go to TRAIL.
  - LOW: `sclk` low for CLK_DIV cycles, then `sclk`→1, go to HIGH.
  - TRAIL: `sclk` low, `cs_n` low for CLK_DIV cycles. Then:
    - `cs_n`→1, `mosi`→0, `done`=1 for exactly one cycle.
    - Read frames: `rdata` updated in the same cycle as `done`.
    - Go to GAP.
  - GAP: `cs_n`=1, `busy`=1 for CLK_DIV cycles, then `busy`=0, go to IDLE.
- Frame timing:
  - Exactly 16 `sclk` rising edges per frame.
  - `cs_n` low for exactly 33·CLK_DIV cycles.
  - Accept to `done` = 1 + 33·CLK_DIV cycles.
  - `cs_n`-high gap between frames ≥ CLK_DIV cycles.
- Boundary conditions:
  - `start` while `busy`: ignored, not queued.
  - Changes on rw/addr/wdata after accept: ignored.
  - `start` held high continuously: back-to-back frames, each separated by the GAP.
  - Write frame: `rdata` unchanged.
  - `miso` X/Z outside a read data phase: never propagates to `rdata`.

Decomposition:
- Package `spi_pkg`:
  - State encoding localparams.
  - FRAME_LEN=16, ADDR_W=7, DATA_W=8.
  - RW_READ=1 / RW_WRITE=0 constants, shared with the peripheral FSM.
- Sub-module `spi_clk_div`: half-period tick generator.
  - Ports: clk, reset, enable, tick.
  - Parameter: CLK_DIV.
  - Clears when enable=0.

Test Plan:
- Reset asserted in IDLE and asserted async between clk edges → `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=0 immediately.
- Write, CLK_DIV=2, addr=0x2A, wdata=0xC5 → `mosi` at the 16 `sclk` rises = 0101010_0_11000101; `cs_n` low 66 cycles; one `done` pulse 67 cycles after accept; `rdata` unchanged.
- Read, CLK_DIV=2, addr=0x7F; peripheral model drives 0x96 on `miso`, changing on `sclk` falls → `mosi` bits 1111111_1_00000000; `rdata`=0x96 in the `done` cycle.
- `start` pulsed again mid-frame, and addr changed to 0x00 after accept → only one frame; transmitted address is still the originally latched value.
- Reset asserted after the 5th `sclk` rise → pins idle at once; next `start` (addr=0x11, write 0xA0) produces a clean full 16-bit frame.
- `start` held high, CLK_DIV=1 → consecutive frames, `cs_n` high ≥1 cycle between frames, one `done` per frame, 16 rises per frame.
